uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Byte-level command controller on the parallel side of the UART, in the same clock domain as the UART receive and transmit paths. It consumes received bytes (RX_P_DATA/RX_DATA_VLD), decodes write, read and ping command frames, and drives the register-file port. Read data and ping replies go back out through the transmitter's TX_P_DATA/TXDATA_VALID handshake, qualified by TX_BUSY.

## Interface
- DATA_WIDTH, 8, byte width of the UART and register-file data.
- ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte.
- clk  in  1  single clock for the whole block.
- ARSTn  in  1  reset, asynchronous, active-low.
- RX_P_DATA  in  DATA_WIDTH  received byte, valid when RX_DATA_VLD=1.
- RX_DATA_VLD  in  1  one-cycle strobe per received byte.
- RX_PAR_ERR  in  1  parity error on the current byte, sampled with RX_DATA_VLD.
- RX_STP_ERR  in  1  stop error on the current byte, sampled with RX_DATA_VLD.
- TX_BUSY  in  1  transmitter busy.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit.
- TXDATA_VALID  out  1  one-cycle transmit request.
- RF_WrEn  out  1  register-file write strobe, one cycle.
- RF_RdEn  out  1  register-file read strobe, one cycle.
- RF_Address  out  ADDR_WIDTH  register-file address.
- RF_WrData  out  DATA_WIDTH  register-file write data.
- RF_RdData  in  DATA_WIDTH  read data, valid with RF_RdData_Valid.
- RF_RdData_Valid  in  1  read-data strobe.
- CMD_ERR  out  1  one-cycle error pulse.

## Operation
- Commands:
  - 0xAA: write frame, 3 bytes (cmd, addr, data); no reply.
  - 0xBB: read frame, 2 bytes (cmd, addr); the controller transmits 1 byte, the read data.
  - 0xDD: ping, 1 byte; the controller transmits 0x55.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND, TX_HOLD.
- IDLE, on an accepted byte:
  - 0xAA -> WR_ADDR.
  - 0xBB -> RD_ADDR.
  - 0xDD -> load 0x55 into the TX register, go to TX_SEND.
  - Any other value -> CMD_ERR pulse, stay in IDLE.
- WR_ADDR: an accepted byte latches its low ADDR_WIDTH bits into RF_Address -> WR_DATA. Upper address bits are ignored.
- WR_DATA: an accepted byte latches into RF_WrData, pulses RF_WrEn -> IDLE.
- RD_ADDR: an accepted byte latches the address, pulses RF_RdEn -> RD_WAIT.
- RD_WAIT: on RF_RdData_Valid, latch RF_RdData into the TX register -> TX_SEND.
- TX_SEND: in the first cycle with TX_BUSY=0, pulse TXDATA_VALID with TX_P_DATA = TX register -> TX_HOLD.
- TX_HOLD: wait for TX_BUSY=1, then for TX_BUSY=0 -> IDLE.
- Accepted byte: RX_DATA_VLD=1 with RX_PAR_ERR=0 and RX_STP_ERR=0.
- Errored byte (RX_DATA_VLD=1 with either error flag set), in IDLE, WR_*, RD_ADDR: CMD_ERR pulse, frame aborted, go to IDLE, no RF strobe.
- Any byte arriving in RD_WAIT, TX_SEND or TX_HOLD: discarded with a CMD_ERR pulse; the state is unaffected.
- RF_Address and RF_WrData hold their last values between commands.

## Timing
- Reset (ARSTn=0), immediate:
  - State IDLE.
  - TX_P_DATA=0, TXDATA_VALID=0, RF_WrEn=0, RF_RdEn=0, RF_Address=0, RF_WrData=0, CMD_ERR=0.
  - TX register cleared.
- All outputs are registered; no combinational input-to-output paths.
- Write: RF_WrEn is high in the cycle after the data byte's RX_DATA_VLD, with RF_Address/RF_WrData already stable in that cycle.
- Read: RF_RdEn is high in the cycle after the address byte's RX_DATA_VLD.
- Reply: TXDATA_VALID is high in the cycle after RF_RdData_Valid if TX_BUSY=0. Otherwise it is high in the cycle after TX_BUSY is first seen low.
- Ping: TXDATA_VALID is high 2 cycles after the 0xDD strobe when TX_BUSY=0.
- CMD_ERR is high in the cycle after the offending RX_DATA_VLD, for exactly 1 cycle.
- RF_RdData_Valid outside RD_WAIT is ignored.
- Back-to-back RX_DATA_VLD on consecutive cycles must be handled; each strobe is one byte.
- Reset asserted mid-frame or mid-TX: the frame is lost, no strobes are emitted after release, and the block waits for a new command byte.

## Test plan
- Write then read: bytes AA,03,5C -> RF_WrEn once, Address=3, WrData=0x5C. Then BB,03 with model RdData=0x5C after 2 cycles -> TXDATA_VALID once with TX_P_DATA=0x5C.
- Ping with TX_BUSY held high 10 cycles: 0xDD -> no TXDATA_VALID while busy; one pulse with 0x55 the cycle after TX_BUSY falls.
- Unknown command 0x17 -> one CMD_ERR pulse, no RF or TX activity. A following AA,0F,FF then writes address 0xF with 0xFF.
- Parity error on the data byte of AA,02,33 -> CMD_ERR, no RF_WrEn. A subsequent ping is answered normally.
- Byte 0x42 received in RD_WAIT -> CMD_ERR; the read completes and returns its data unchanged.
- Reset asserted after AA,05 -> all outputs 0 immediately. After release, byte 0x11 gives CMD_ERR and no write occurs.

Source files
------------

// File: rtl/uart_cmd_ctrl_if.sv
// Parallel-side bundle between the UART command controller, the UART RX/TX paths
// and the register file. The master modport is the controller's view.
interface uart_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_DATA_VLD;
  logic                  RX_PAR_ERR;
  logic                  RX_STP_ERR;
  logic                  TX_BUSY;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TXDATA_VALID;
  logic                  RF_WrEn;
  logic                  RF_RdEn;
  logic [ADDR_WIDTH-1:0] RF_Address;
  logic [DATA_WIDTH-1:0] RF_WrData;
  logic [DATA_WIDTH-1:0] RF_RdData;
  logic                  RF_RdData_Valid;
  logic                  CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_DATA_VLD, RX_PAR_ERR, RX_STP_ERR, TX_BUSY,
    input  RF_RdData, RF_RdData_Valid,
    output TX_P_DATA, TXDATA_VALID, RF_WrEn, RF_RdEn, RF_Address, RF_WrData, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_DATA_VLD, RX_PAR_ERR, RX_STP_ERR, TX_BUSY,
    output RF_RdData, RF_RdData_Valid,
    input  TX_P_DATA, TXDATA_VALID, RF_WrEn, RF_RdEn, RF_Address, RF_WrData, CMD_ERR
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Byte-level command decoder: write (AA,addr,data), read (BB,addr) and ping (DD)
// frames drive the register-file port; read data and ping replies go to the UART TX.
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic            clk,
  input  logic            ARSTn,
  uart_cmd_ctrl_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_PING   = DATA_WIDTH'(8'hDD);
  localparam logic [DATA_WIDTH-1:0] PING_REPLY = DATA_WIDTH'(8'h55);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5,
    ST_TX_HOLD = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic                  seen_busy_q, seen_busy_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  txvld_q, txvld_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic                  err_q, err_d;

  logic byte_ok_s;
  logic byte_bad_s;

  assign byte_ok_s  = bus.RX_DATA_VLD & ~bus.RX_PAR_ERR & ~bus.RX_STP_ERR;
  assign byte_bad_s = bus.RX_DATA_VLD & (bus.RX_PAR_ERR | bus.RX_STP_ERR);

  // State register and the busy-seen flag used while holding for TX completion.
  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q     <= ST_IDLE;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    seen_busy_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_ok_s) begin
          case (bus.RX_P_DATA)
            CMD_WR:   state_d = ST_WR_ADDR;
            CMD_RD:   state_d = ST_RD_ADDR;
            CMD_PING: state_d = ST_TX_SEND;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_ADDR: begin
        if (byte_ok_s)       state_d = ST_WR_DATA;
        else if (byte_bad_s) state_d = ST_IDLE;
        else                 state_d = ST_WR_ADDR;
      end
      ST_WR_DATA: begin
        if (bus.RX_DATA_VLD) state_d = ST_IDLE;
        else                 state_d = ST_WR_DATA;
      end
      ST_RD_ADDR: begin
        if (byte_ok_s)       state_d = ST_RD_WAIT;
        else if (byte_bad_s) state_d = ST_IDLE;
        else                 state_d = ST_RD_ADDR;
      end
      ST_RD_WAIT: begin
        // An idle transmitter takes the reply straight away, skipping TX_SEND.
        if (bus.RF_RdData_Valid) state_d = bus.TX_BUSY ? ST_TX_SEND : ST_TX_HOLD;
        else                     state_d = ST_RD_WAIT;
      end
      ST_TX_SEND: begin
        if (!bus.TX_BUSY) state_d = ST_TX_HOLD;
        else              state_d = ST_TX_SEND;
      end
      ST_TX_HOLD: begin
        if (seen_busy_q && !bus.TX_BUSY) begin
          state_d     = ST_IDLE;
          seen_busy_d = 1'b0;
        end else begin
          state_d     = ST_TX_HOLD;
          seen_busy_d = seen_busy_q | bus.TX_BUSY;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        seen_busy_d = 1'b0;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    tx_d     = tx_q;
    txvld_d  = 1'b0;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_ok_s) begin
          case (bus.RX_P_DATA)
            CMD_WR:   err_d = 1'b0;
            CMD_RD:   err_d = 1'b0;
            CMD_PING: tx_d  = PING_REPLY;
            default:  err_d = 1'b1;
          endcase
        end else begin
          err_d = byte_bad_s;
        end
      end
      ST_WR_ADDR: begin
        if (byte_ok_s) addr_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
        else           err_d  = byte_bad_s;
      end
      ST_WR_DATA: begin
        if (byte_ok_s) begin
          wrdata_d = bus.RX_P_DATA;
          wren_d   = 1'b1;
        end else begin
          err_d = byte_bad_s;
        end
      end
      ST_RD_ADDR: begin
        if (byte_ok_s) begin
          addr_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          rden_d = 1'b1;
        end else begin
          err_d = byte_bad_s;
        end
      end
      ST_RD_WAIT: begin
        err_d = bus.RX_DATA_VLD;
        if (bus.RF_RdData_Valid) begin
          tx_d    = bus.RF_RdData;
          txvld_d = ~bus.TX_BUSY;
        end else begin
          txvld_d = 1'b0;
        end
      end
      ST_TX_SEND: begin
        err_d   = bus.RX_DATA_VLD;
        txvld_d = ~bus.TX_BUSY;
      end
      ST_TX_HOLD: begin
        err_d = bus.RX_DATA_VLD;
      end
      default: begin
        err_d = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      tx_q     <= '0;
      txvld_q  <= 1'b0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      tx_q     <= tx_d;
      txvld_q  <= txvld_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.TX_P_DATA    = tx_q;
  assign bus.TXDATA_VALID = txvld_q;
  assign bus.RF_WrEn      = wren_q;
  assign bus.RF_RdEn      = rden_q;
  assign bus.RF_Address   = addr_q;
  assign bus.RF_WrData    = wrdata_q;
  assign bus.CMD_ERR      = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a small register-file responder and a
// transmitter model that goes busy for a few cycles after each TXDATA_VALID.
module tb_uart_cmd_ctrl;

  logic clk = 1'b0;
  logic ARSTn;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ifc ();

  uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .ARSTn (ARSTn),
    .bus   (ifc.master)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int drv_cyc, fall_cyc;

  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0;
  int wr_cyc, rd_cyc, tx_cyc, err_cyc, rv_cyc;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, tx_data;
  logic [7:0] rf_mem [16];
  int rf_dly = 0;
  int busy_cnt = 0;
  logic busy_force;
  int w0, r0, t0, e0;

  assign ifc.TX_BUSY = busy_force | (busy_cnt != 0);

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus register-file and transmitter responders, all away from the active edge.
  always @(negedge clk) begin
    if (!ARSTn) begin
      rf_dly              <= 0;
      busy_cnt            <= 0;
      ifc.RF_RdData_Valid <= 1'b0;
      ifc.RF_RdData       <= 8'h00;
    end else begin
      ifc.RF_RdData_Valid <= (rf_dly == 1);
      if (rf_dly == 1) begin
        ifc.RF_RdData <= rf_mem[rd_addr];
        rv_cyc        <= cyc;
      end
      if (ifc.RF_RdEn) begin
        rf_dly  <= 2;
        rd_addr <= ifc.RF_Address;
        rd_cnt  <= rd_cnt + 1;
        rd_cyc  <= cyc;
      end else if (rf_dly != 0) begin
        rf_dly <= rf_dly - 1;
      end
      if (ifc.RF_WrEn) begin
        rf_mem[ifc.RF_Address] <= ifc.RF_WrData;
        wr_cnt  <= wr_cnt + 1;
        wr_cyc  <= cyc;
        wr_addr <= ifc.RF_Address;
        wr_data <= ifc.RF_WrData;
      end
      if (ifc.TXDATA_VALID) begin
        busy_cnt <= 4;
        tx_cnt   <= tx_cnt + 1;
        tx_cyc   <= cyc;
        tx_data  <= ifc.TX_P_DATA;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end
      if (ifc.CMD_ERR) begin
        err_cnt <= err_cnt + 1;
        err_cyc <= cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic par, input logic stp);
    @(negedge clk);
    ifc.RX_P_DATA   = d;
    ifc.RX_DATA_VLD = 1'b1;
    ifc.RX_PAR_ERR  = par;
    ifc.RX_STP_ERR  = stp;
    drv_cyc         = cyc;
  endtask

  task automatic release_rx();
    @(negedge clk);
    ifc.RX_P_DATA   = 8'h00;
    ifc.RX_DATA_VLD = 1'b0;
    ifc.RX_PAR_ERR  = 1'b0;
    ifc.RX_STP_ERR  = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    w0 = wr_cnt; r0 = rd_cnt; t0 = tx_cnt; e0 = err_cnt;
  endtask

  function automatic logic [31:0] outs_packed();
    return 32'({ifc.TX_P_DATA, ifc.TXDATA_VALID, ifc.RF_WrEn, ifc.RF_RdEn,
                ifc.RF_Address, ifc.RF_WrData, ifc.CMD_ERR});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARSTn           = 1'b0;
    busy_force      = 1'b0;
    ifc.RX_P_DATA   = 8'h00;
    ifc.RX_DATA_VLD = 1'b0;
    ifc.RX_PAR_ERR  = 1'b0;
    ifc.RX_STP_ERR  = 1'b0;
    #1;
    check_eq("reset_outputs", outs_packed(), 32'h0);
    repeat (2) @(negedge clk);
    ARSTn = 1'b1;
    wait_cyc(2);

    // Write AA,03,5C back-to-back.
    snap();
    drive(8'hAA, 1'b0, 1'b0); drive(8'h03, 1'b0, 1'b0); drive(8'h5C, 1'b0, 1'b0);
    release_rx();
    wait_cyc(3);
    check_eq("wr_count",   32'(wr_cnt - w0), 32'd1);
    check_eq("wr_addr",    32'(wr_addr), 32'h3);
    check_eq("wr_data",    32'(wr_data), 32'h5C);
    check_eq("wr_latency", 32'(wr_cyc - drv_cyc), 32'd1);
    check_eq("wr_no_err",  32'(err_cnt - e0), 32'd0);

    // Read BB,03: responder answers two cycles after RF_RdEn.
    snap();
    drive(8'hBB, 1'b0, 1'b0); drive(8'h03, 1'b0, 1'b0);
    release_rx();
    wait_cyc(15);
    check_eq("rd_count",   32'(rd_cnt - r0), 32'd1);
    check_eq("rd_latency", 32'(rd_cyc - drv_cyc), 32'd1);
    check_eq("rd_tx_count", 32'(tx_cnt - t0), 32'd1);
    check_eq("rd_tx_data", 32'(tx_data), 32'h5C);
    check_eq("rd_tx_latency", 32'(tx_cyc - rv_cyc), 32'd1);
    check_eq("rd_no_write", 32'(wr_cnt - w0), 32'd0);

    // Ping while the transmitter is held busy for 10 cycles.
    snap();
    busy_force = 1'b1;
    drive(8'hDD, 1'b0, 1'b0);
    release_rx();
    wait_cyc(9);
    check_eq("ping_busy_no_tx", 32'(tx_cnt - t0), 32'd0);
    @(negedge clk);
    busy_force = 1'b0;
    fall_cyc   = cyc;
    wait_cyc(10);
    check_eq("ping_busy_tx_count", 32'(tx_cnt - t0), 32'd1);
    check_eq("ping_busy_tx_data", 32'(tx_data), 32'h55);
    check_eq("ping_busy_latency", 32'(tx_cyc - fall_cyc), 32'd1);

    // Unknown command, then a write whose address/data are all ones.
    snap();
    drive(8'h17, 1'b0, 1'b0);
    release_rx();
    wait_cyc(3);
    check_eq("unk_err_count", 32'(err_cnt - e0), 32'd1);
    check_eq("unk_err_latency", 32'(err_cyc - drv_cyc), 32'd1);
    check_eq("unk_no_activity", 32'((wr_cnt - w0) + (rd_cnt - r0) + (tx_cnt - t0)), 32'd0);
    drive(8'hAA, 1'b0, 1'b0); drive(8'h0F, 1'b0, 1'b0); drive(8'hFF, 1'b0, 1'b0);
    release_rx();
    wait_cyc(3);
    check_eq("wrF_count", 32'(wr_cnt - w0), 32'd1);
    check_eq("wrF_addr", 32'(wr_addr), 32'hF);
    check_eq("wrF_data", 32'(wr_data), 32'hFF);
    check_eq("wrF_err_single", 32'(err_cnt - e0), 32'd1);

    // Upper address bits are dropped: A6 addresses register 6.
    drive(8'hAA, 1'b0, 1'b0); drive(8'hA6, 1'b0, 1'b0); drive(8'h12, 1'b0, 1'b0);
    release_rx();
    wait_cyc(3);
    check_eq("wr_upper_addr", 32'(wr_addr), 32'h6);
    check_eq("wr_upper_data", 32'(wr_data), 32'h12);

    // Parity error on the data byte aborts the write.
    snap();
    drive(8'hAA, 1'b0, 1'b0); drive(8'h02, 1'b0, 1'b0); drive(8'h33, 1'b1, 1'b0);
    release_rx();
    wait_cyc(3);
    check_eq("par_err_count", 32'(err_cnt - e0), 32'd1);
    check_eq("par_no_write", 32'(wr_cnt - w0), 32'd0);
    check_eq("par_wrdata_held", 32'(ifc.RF_WrData), 32'h12);
    snap();
    drive(8'hDD, 1'b0, 1'b0);
    release_rx();
    wait_cyc(10);
    check_eq("ping_tx_count", 32'(tx_cnt - t0), 32'd1);
    check_eq("ping_tx_data", 32'(tx_data), 32'h55);
    check_eq("ping_latency", 32'(tx_cyc - drv_cyc), 32'd2);

    // Stop error on the address byte of a read aborts it.
    snap();
    drive(8'hBB, 1'b0, 1'b0); drive(8'h03, 1'b0, 1'b1);
    release_rx();
    wait_cyc(6);
    check_eq("stp_err_count", 32'(err_cnt - e0), 32'd1);
    check_eq("stp_no_read", 32'(rd_cnt - r0), 32'd0);

    // Stray byte 0x42 during RD_WAIT.
    snap();
    drive(8'hBB, 1'b0, 1'b0); drive(8'h03, 1'b0, 1'b0); drive(8'h42, 1'b0, 1'b0);
    release_rx();
    wait_cyc(15);
    check_eq("rdwait_err_count", 32'(err_cnt - e0), 32'd1);
    check_eq("rdwait_rd_count", 32'(rd_cnt - r0), 32'd1);
    check_eq("rdwait_tx_count", 32'(tx_cnt - t0), 32'd1);
    check_eq("rdwait_tx_data", 32'(tx_data), 32'h5C);

    // Reset in the middle of a write frame.
    snap();
    drive(8'hAA, 1'b0, 1'b0); drive(8'h05, 1'b0, 1'b0);
    release_rx();
    wait_cyc(2);
    check_eq("mid_addr_latched", 32'(ifc.RF_Address), 32'h5);
    #2;
    ARSTn = 1'b0;
    #1;
    check_eq("mid_reset_outputs", outs_packed(), 32'h0);
    @(negedge clk);
    ARSTn = 1'b1;
    drive(8'h11, 1'b0, 1'b0);
    release_rx();
    wait_cyc(4);
    check_eq("post_reset_err", 32'(err_cnt - e0), 32'd1);
    check_eq("post_reset_no_write", 32'(wr_cnt - w0), 32'd0);
    check_eq("post_reset_addr", 32'(ifc.RF_Address), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
